// File: rtl/framebuffer_scanout.sv
// 64x64x8 single-port framebuffer: renderer writes go through a 4-entry FIFO,
// a clear sweep zero-fills the buffer, and the buffer scans out 4x-scaled RGB332.
module framebuffer_scanout (
    input  logic        clk,
    input  logic        reset,
    input  logic        display_on,
    input  logic [8:0]  hpos,
    input  logic [8:0]  vpos,
    input  logic        we,
    input  logic [11:0] addr,
    input  logic [7:0]  ram_d,
    input  logic        clear,
    output logic [7:0]  rgb,
    output logic        wr_full,
    output logic        clear_busy,
    output logic [7:0]  drop_count
);
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t      state;
    logic [11:0] sweep;

    logic [7:0]  mem [0:4095];
    logic [7:0]  ram_q;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;

    logic [11:0] fifo_addr [0:3];
    logic [7:0]  fifo_data [0:3];
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [2:0]  count;

    logic        in_win;
    logic        disp_slot;
    logic        clear_slot;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        push;
    logic        lost;

    logic        rd_d1;
    logic        win_d1;
    logic        win_d2;
    logic [7:0]  pix;

    // Write port has no backpressure: a strobe with we=1 is either queued or
    // counted as lost in the same cycle; wr_full is status only.
    always_comb begin
        in_win     = display_on & ~hpos[8] & ~vpos[8];
        disp_slot  = in_win & (hpos[1:0] == 2'b00);
        clear_slot = ~disp_slot & (state == CLEAR);
        fifo_empty = (count == 3'd0);
        fifo_full  = (count == 3'd4);
        pop        = ~disp_slot & (state == IDLE) & ~fifo_empty;
        push       = we & (~fifo_full | pop);
        lost       = we & fifo_full & ~pop;
    end

    // Single RAM port: display read, then clear write, then FIFO drain.
    always_comb begin
        ram_addr  = {vpos[7:2], hpos[7:2]};
        ram_we    = 1'b0;
        ram_wdata = 8'h00;
        if (clear_slot) begin
            ram_addr = sweep;
            ram_we   = 1'b1;
        end else if (pop) begin
            ram_addr  = fifo_addr[rd_ptr];
            ram_we    = 1'b1;
            ram_wdata = fifo_data[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        else if (disp_slot)
            ram_q <= mem[ram_addr];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= addr;
            fifo_data[wr_ptr] <= ram_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= 2'd0;
            wr_ptr     <= 2'd0;
            count      <= 3'd0;
            drop_count <= 8'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (lost && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end
    end

    // A clear pulse inside a sweep restarts it from address 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sweep <= 12'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        state <= CLEAR;
                        sweep <= 12'd0;
                    end
                end
                CLEAR: begin
                    if (clear) begin
                        sweep <= 12'd0;
                    end else if (clear_slot) begin
                        if (sweep == 12'hFFF)
                            state <= IDLE;
                        sweep <= sweep + 12'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_d1  <= 1'b0;
            win_d1 <= 1'b0;
            win_d2 <= 1'b0;
            pix    <= 8'h00;
        end else begin
            rd_d1  <= disp_slot;
            win_d1 <= in_win;
            win_d2 <= win_d1;
            if (rd_d1)
                pix <= ram_q;
        end
    end

    assign rgb        = win_d2 ? pix : 8'h00;
    assign wr_full    = fifo_full;
    assign clear_busy = (state == CLEAR);

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout: queue/array reference model checked every
// cycle, plus table-driven burst vectors and hand-derived screen probes.
module tb_framebuffer_scanout;
    logic        clk = 1'b0;
    logic        reset;
    logic        display_on;
    logic [8:0]  hpos;
    logic [8:0]  vpos;
    logic        we;
    logic [11:0] addr;
    logic [7:0]  ram_d;
    logic        clear;
    logic [7:0]  rgb;
    logic        wr_full;
    logic        clear_busy;
    logic [7:0]  drop_count;

    framebuffer_scanout dut (
        .clk        (clk),
        .reset      (reset),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos),
        .we         (we),
        .addr       (addr),
        .ram_d      (ram_d),
        .clear      (clear),
        .rgb        (rgb),
        .wr_full    (wr_full),
        .clear_busy (clear_busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {logic [11:0] a; logic [7:0] d;} wr_t;
    typedef struct {int h; int v; bit win;} pos_t;
    typedef struct {logic [11:0] a; logic [7:0] d; bit exp_full; int exp_drop;} burst_vec_t;
    typedef struct {int v; int h; int exp;} probe_t;

    wr_t        m_q[$];
    logic [7:0] m_mem [4096];
    bit         m_clearing;
    int         m_sweep;
    int         m_drop;
    logic [7:0] m_last;
    logic [7:0] exp_q[$];
    pos_t       pos_q[$];

    logic [7:0] scr [12][32];
    logic [7:0] seen [64][64];
    burst_vec_t burst_tab [8];
    probe_t     probe_tab [12];
    logic [7:0] av_data [8];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_clearing = 1'b0;
        m_sweep    = 0;
        m_drop     = 0;
        m_last     = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'h00);
        pos_q.delete();
        pos_q.push_back('{0, 0, 1'b0});
    endtask

    // One clock of the reference behaviour, computed from the current inputs.
    task automatic model_step();
        bit  win;
        int  a;
        wr_t w;
        win = display_on && (hpos < 256) && (vpos < 256);
        a   = (int'(vpos) / 4) * 64 + int'(hpos) / 4;
        if (win && (hpos % 4 == 0)) begin
            m_last = m_mem[a];
        end else if (m_clearing) begin
            m_mem[m_sweep] = 8'h00;
            m_sweep++;
        end else if (m_q.size() > 0) begin
            w = m_q.pop_front();
            m_mem[w.a] = w.d;
        end
        if (clear) begin
            m_clearing = 1'b1;
            m_sweep    = 0;
        end else if (m_sweep == 4096) begin
            m_clearing = 1'b0;
            m_sweep    = 0;
        end
        if (we) begin
            if (m_q.size() < 4)
                m_q.push_back('{addr, ram_d});
            else if (m_drop < 255)
                m_drop++;
        end
        exp_q.push_back(win ? m_last : 8'h00);
        pos_q.push_back('{int'(hpos), int'(vpos), win});
    endtask

    task automatic check_outputs();
        pos_t       p;
        logic [7:0] e;
        p = pos_q.pop_front();
        e = exp_q.pop_front();
        check("rgb", int'(rgb), int'(e));
        check("wr_full", int'(wr_full), (m_q.size() == 4) ? 1 : 0);
        check("clear_busy", int'(clear_busy), int'(m_clearing));
        check("drop_count", int'(drop_count), m_drop);
        if (p.win) begin
            if (p.v < 12 && p.h < 32)
                scr[p.v][p.h] = rgb;
            if (p.v % 4 == 0 && p.h % 4 == 2)
                seen[p.v / 4][p.h / 4] = rgb;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        display_on = 1'b0;
        hpos       = 9'd300;
        vpos       = 9'd300;
        we         = 1'b0;
        addr       = 12'h000;
        ram_d      = 8'h00;
        clear      = 1'b0;
    endtask

    task automatic write1(input logic [11:0] a, input logic [7:0] d);
        we    = 1'b1;
        addr  = a;
        ram_d = d;
        tick();
        we    = 1'b0;
    endtask

    task automatic scan_line(input int v);
        for (int h = 0; h < 264; h++) begin
            display_on = (h < 256);
            hpos       = 9'(h);
            vpos       = 9'(v);
            tick();
        end
        display_on = 1'b0;
    endtask

    task automatic wait_clear_done(input string name);
        int n;
        n = 0;
        while (clear_busy && n < 7000) begin
            tick();
            n++;
        end
        if (n >= 7000)
            bound_fail(name);
        repeat (8) tick();
    endtask

    // Blanking-time sweep; optionally queues one write wr_at cycles into it.
    task automatic do_clear(input int wr_at, input logic [11:0] wa, input logic [7:0] wd,
                            output int busy);
        int n;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        busy  = int'(clear_busy);
        n     = 0;
        while (clear_busy && n < 7000) begin
            if (n == wr_at) begin
                we    = 1'b1;
                addr  = wa;
                ram_d = wd;
            end
            tick();
            we = 1'b0;
            busy += int'(clear_busy);
            n++;
        end
        if (n >= 7000)
            bound_fail("clear_done");
        repeat (8) tick();
    endtask

    initial begin
        int busy;
        int cnt;

        for (int i = 0; i < 8; i++) begin
            burst_tab[i].a        = 12'h100 + 12'(i);
            burst_tab[i].d        = 8'($urandom_range(1, 255));
            burst_tab[i].exp_full = (i >= 3);
            burst_tab[i].exp_drop = (i > 3) ? i - 3 : 0;
        end
        probe_tab[0]  = '{4, 4, 8'hE0};
        probe_tab[1]  = '{4, 7, 8'hE0};
        probe_tab[2]  = '{7, 4, 8'hE0};
        probe_tab[3]  = '{7, 7, 8'hE0};
        probe_tab[4]  = '{5, 6, 8'hE0};
        probe_tab[5]  = '{3, 4, 8'h00};
        probe_tab[6]  = '{8, 4, 8'h00};
        probe_tab[7]  = '{4, 3, 8'h00};
        probe_tab[8]  = '{4, 8, 8'h00};
        probe_tab[9]  = '{0, 0, 8'h22};
        probe_tab[10] = '{3, 3, 8'h22};
        probe_tab[11] = '{0, 4, 8'h00};
        for (int a = 0; a < 4096; a++)
            m_mem[a] = 8'h00;

        // Reset with no activity.
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rgb", int'(rgb), 0);
        check("rst_wr_full", int'(wr_full), 0);
        check("rst_clear_busy", int'(clear_busy), 0);
        check("rst_drop", int'(drop_count), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) tick();

        // Establish known RAM contents.
        do_clear(-1, 12'h000, 8'h00, busy);
        check("clear_len_blank", busy, 4096);

        // Single pixel plus same-address overwrite, then scan the top of screen.
        write1(12'h041, 8'hE0);
        write1(12'h000, 8'h11);
        write1(12'h000, 8'h22);
        repeat (4) tick();
        for (int v = 0; v < 12; v++)
            scan_line(v);
        for (int i = 0; i < 12; i++)
            check("probe", int'(scr[probe_tab[i].v][probe_tab[i].h]), probe_tab[i].exp);
        cnt = 0;
        for (int v = 0; v < 12; v++)
            for (int h = 0; h < 32; h++)
                if (scr[v][h] == 8'hE0)
                    cnt++;
        check("e0_pixel_count", cnt, 16);

        // Burst of 8 distinct writes while the sweep holds off draining.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 8; i++) begin
            write1(burst_tab[i].a, burst_tab[i].d);
            check("burst_full", int'(wr_full), int'(burst_tab[i].exp_full));
            check("burst_drop", int'(drop_count), burst_tab[i].exp_drop);
        end
        wait_clear_done("burst_clear");

        // Burst during active video on line 20; data lands in fb row 8.
        for (int i = 0; i < 8; i++)
            av_data[i] = 8'($urandom_range(1, 255));
        for (int h = 0; h < 264; h++) begin
            display_on = (h < 256);
            hpos       = 9'(h);
            vpos       = 9'd20;
            we         = (h >= 40 && h < 48);
            addr       = 12'h200 + 12'((h - 40) & 7);
            ram_d      = av_data[(h - 40) & 7];
            tick();
        end
        we = 1'b0;
        display_on = 1'b0;
        repeat (4) tick();
        scan_line(32);
        for (int i = 0; i < 8; i++)
            check("active_burst_pix", int'(seen[8][i]), int'(av_data[i]));

        // Fill with 0xFF, then sweep with one write queued mid-sweep.
        for (int a = 0; a < 4096; a++)
            write1(12'(a), 8'hFF);
        repeat (4) tick();
        do_clear(2000, 12'h800, 8'h1C, busy);
        check("clear_len_fill", busy, 4096);
        for (int r = 0; r < 64; r++)
            scan_line(4 * r);
        cnt = 0;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                if (seen[r][c] != 8'h00)
                    cnt++;
        check("nonzero_after_clear", cnt, 1);
        check("pix_0x800", int'(seen[32][0]), 8'h1C);

        // 300 writes against a FIFO that cannot drain.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 300; i++)
            write1(12'($urandom_range(0, 4095)), 8'($urandom_range(0, 255)));
        check("drop_saturated", int'(drop_count), 255);
        wait_clear_done("sat_clear");

        // Randomised raster with writes to a small hot region.
        for (int line = 0; line < 10; line++) begin
            int v;
            v = $urandom_range(0, 15);
            for (int h = 0; h < 320; h++) begin
                display_on = (h < 256);
                hpos       = 9'(h);
                vpos       = 9'(v);
                we         = ($urandom_range(0, 1) == 1);
                addr       = {6'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
                ram_d      = 8'($urandom_range(0, 255));
                clear      = ($urandom_range(0, 1999) == 0);
                tick();
            end
        end
        we = 1'b0;
        clear = 1'b0;
        display_on = 1'b0;
        wait_clear_done("random_clear");
        for (int r = 0; r < 4; r++)
            scan_line(4 * r);

        // Asynchronous reset mid-sweep with a full FIFO.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 5; i++)
            write1(12'h300 + 12'(i), 8'h5A);
        check("pre_rst_full", int'(wr_full), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_rgb", int'(rgb), 0);
        check("async_rst_wr_full", int'(wr_full), 0);
        check("async_rst_clear_busy", int'(clear_busy), 0);
        check("async_rst_drop", int'(drop_count), 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) tick();
        scan_line(0);
        scan_line(48);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
